// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio voice blocks.
//   voice_state_t : voice sequencing states (IDLE / PLAY / FADE)
//   DATA_W_DEF    : default sample width
//   sample_t      : signed sample at the default width
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        FADE = 2'd2
    } voice_state_t;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/wavetable_voice_if.sv
// ---------------------------------------------------------------------------
// wavetable_voice_if
// Bundles the voice control, table-write and audio output signals.
//   master : sequencer / table loader side (drives start, stop, step_div,
//            repeats, tbl_*; observes busy, done, audio_out)
//   slave  : the voice itself
// ---------------------------------------------------------------------------
interface wavetable_voice_if #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int DIV_W      = 16,
    parameter int REP_W      = 4
);

    logic                  start;
    logic                  stop;
    logic [DIV_W-1:0]      step_div;
    logic [REP_W-1:0]      repeats;
    logic                  tbl_we;
    logic [DEPTH_LOG2-1:0] tbl_waddr;
    logic [DATA_W-1:0]     tbl_wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     audio_out;

    modport master (
        output start, stop, step_div, repeats, tbl_we, tbl_waddr, tbl_wdata,
        input  busy, done, audio_out
    );

    modport slave (
        input  start, stop, step_div, repeats, tbl_we, tbl_waddr, tbl_wdata,
        output busy, done, audio_out
    );

endinterface

// File: rtl/wave_table_ram.sv
// ---------------------------------------------------------------------------
// wave_table_ram
// Simple dual-port table: one synchronous write port, one synchronous read
// port. A read of the address being written in the same cycle returns the
// old contents. No reset, so table contents survive a voice reset.
//   clock : write and read clock
//   we, waddr, wdata : write port
//   raddr, rdata     : read port, rdata valid one clock after raddr
// ---------------------------------------------------------------------------
module wave_table_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write and read in one process with non-blocking assignments so a
    // colliding read sees the pre-write value; this maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wavetable_voice.sv
// ---------------------------------------------------------------------------
// wavetable_voice
// Single-voice wavetable note generator. On start it plays the table
// `repeats` times at full amplitude, each entry held step_div clocks, then
// plays FADE_PASSES further passes with pass f scaled by >>> (f+1), then
// returns to idle and pulses done as the last faded sample leaves audio_out.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : start/stop/step_div/repeats note control, tbl_* table
//                  write port, busy/done/audio_out status and audio
// ---------------------------------------------------------------------------
module wavetable_voice
    import audio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_LOG2  = 6,
    parameter int DIV_W       = 16,
    parameter int REP_W       = 4,
    parameter int FADE_PASSES = 3
) (
    input  logic            clock,
    input  logic            reset,
    wavetable_voice_if.slave bus
);

    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int FADE_W = $clog2(FADE_PASSES + 1);
    localparam int PASS_W = (REP_W > FADE_W) ? REP_W : FADE_W;

    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR      = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [PASS_W-1:0]     LAST_FADE_PASS = PASS_W'(FADE_PASSES - 1);

    voice_state_t          state;
    logic [DIV_W-1:0]      div_q;
    logic [REP_W-1:0]      reps_q;
    logic [DIV_W-1:0]      div_cnt;
    logic [DEPTH_LOG2-1:0] addr;
    logic [PASS_W-1:0]     pass_cnt;
    logic                  busy_q;
    logic                  done_arm;
    logic                  done_dly;
    logic                  done_q;

    logic                  rd_valid;
    logic [FADE_W-1:0]     rd_shift;
    logic [DATA_W-1:0]     rdata;
    logic signed [DATA_W-1:0] scaled;
    logic [DATA_W-1:0]     audio_q;

    logic entry_end;
    logic last_play_pass;
    logic stop_now;

    // Table storage; read address is the running entry pointer.
    wave_table_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_table (
        .clock (clock),
        .we    (bus.tbl_we),
        .waddr (bus.tbl_waddr),
        .wdata (bus.tbl_wdata),
        .raddr (addr),
        .rdata (rdata)
    );

    assign entry_end      = (div_cnt == (div_q - DIV_W'(1)));
    assign last_play_pass = (pass_cnt == PASS_W'(reps_q - REP_W'(1)));
    assign stop_now       = bus.stop && (state != IDLE);

    // Shift kept in its own assignment so the arithmetic shift stays signed
    // and is not turned unsigned by the zero arm of the output mux.
    assign scaled = $signed(rdata) >>> rd_shift;

    // Note sequencer: latches the note parameters on an accepted start,
    // then walks div_cnt -> addr -> pass_cnt. Passes are counted at the
    // address wrap; the final FADE pass returns to IDLE and arms done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_q    <= '0;
            reps_q   <= '0;
            div_cnt  <= '0;
            addr     <= '0;
            pass_cnt <= '0;
            busy_q   <= 1'b0;
            done_arm <= 1'b0;
        end else begin
            done_arm <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div_q    <= (bus.step_div == '0) ? DIV_W'(1) : bus.step_div;
                        reps_q   <= bus.repeats;
                        div_cnt  <= '0;
                        addr     <= '0;
                        pass_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= (bus.repeats == '0) ? FADE : PLAY;
                    end
                end
                PLAY, FADE: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (entry_end) begin
                        div_cnt <= '0;
                        addr    <= addr + DEPTH_LOG2'(1);
                        if (addr == LAST_ADDR) begin
                            if ((state == PLAY) && last_play_pass) begin
                                state    <= FADE;
                                pass_cnt <= '0;
                            end else if ((state == FADE) && (pass_cnt == LAST_FADE_PASS)) begin
                                state    <= IDLE;
                                busy_q   <= 1'b0;
                                done_arm <= 1'b1;
                            end else begin
                                pass_cnt <= pass_cnt + PASS_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Output pipeline: the fade shift and a valid flag travel alongside the
    // one-clock table read, then the scaled sample is registered. done is
    // delayed by the same two stages so it lines up with the last sample
    // leaving audio_out. A stop clears the pipeline so audio drops at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_shift <= '0;
            audio_q  <= '0;
            done_dly <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_dly <= done_arm;
            done_q   <= done_dly;
            if (stop_now) begin
                rd_valid <= 1'b0;
                audio_q  <= '0;
            end else begin
                rd_valid <= (state != IDLE);
                rd_shift <= (state == FADE) ? (FADE_W'(pass_cnt) + FADE_W'(1)) : '0;
                audio_q  <= rd_valid ? scaled : '0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.audio_out = audio_q;

endmodule

// File: tb/tb_wavetable_voice.sv
// ---------------------------------------------------------------------------
// tb_wavetable_voice
// Scoreboard bench for wavetable_voice. Each note stimulus pushes the
// expected per-cycle {audio_out, busy, done} trace; a monitor pops and
// compares one record every falling edge.
// ---------------------------------------------------------------------------
module tb_wavetable_voice;
    import audio_pkg::*;

    localparam int DATA_W      = 32;
    localparam int DEPTH_LOG2  = 6;
    localparam int DIV_W       = 16;
    localparam int REP_W       = 4;
    localparam int FADE_PASSES = 3;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int NO_SWITCH   = 1000000;

    typedef struct {
        int   audio;
        logic busy;
        logic done;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;
    rec_t expq[$];
    int   tblA[DEPTH];
    int   tblB[DEPTH];

    wavetable_voice_if #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .DIV_W(DIV_W), .REP_W(REP_W)
    ) bus ();

    wavetable_voice #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .DIV_W(DIV_W),
        .REP_W(REP_W), .FADE_PASSES(FADE_PASSES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Compare one expected record against the live DUT outputs.
    task automatic checkOutput(input rec_t e);
        sample_t act;
        act = bus.audio_out;
        nChecks++;
        if (act != e.audio) begin
            nErrors++;
            $display("[TB] FAIL audio_out @%0t: got %0d expected %0d", $time, act, e.audio);
        end
        nChecks++;
        if (bus.busy !== e.busy) begin
            nErrors++;
            $display("[TB] FAIL busy @%0t: got %0b expected %0b", $time, bus.busy, e.busy);
        end
        nChecks++;
        if (bus.done !== e.done) begin
            nErrors++;
            $display("[TB] FAIL done @%0t: got %0b expected %0b", $time, bus.done, e.done);
        end
    endtask

    // Monitor: one record per falling edge while the scoreboard is non-empty.
    initial begin
        rec_t e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic pushZero();
        rec_t z;
        z.audio = 0;
        z.busy  = 1'b0;
        z.done  = 1'b0;
        expq.push_back(z);
    endtask

    // Expected trace of a note whose start was sampled on edge E0; record k
    // is checked just after edge Ek. stopAt: edge sampling stop (-1 none).
    // switchJ: samples from this index on use tblB. cutAt: reset lands just
    // after this edge, record cutAt is all-zero and the trace ends there.
    task automatic pushTrace(input int div, input int rep, input int stopAt,
                             input int switchJ, input int cutAt);
        int eff, total, last;
        eff   = (div == 0) ? 1 : div;
        total = (rep + FADE_PASSES) * DEPTH * eff;
        last  = (cutAt >= 0) ? cutAt : total + 3;
        for (int k = 0; k <= last; k++) begin
            rec_t r;
            int   j, entry, pass, val, sh;
            bit   live;
            live    = (stopAt < 0) || (k < stopAt);
            r.busy  = (k < total) && live;
            r.done  = (k == total + 2) && (stopAt < 0);
            r.audio = 0;
            if (k >= 2 && (k - 2) < total && live) begin
                j     = k - 2;
                entry = (j / eff) % DEPTH;
                pass  = j / (eff * DEPTH);
                val   = (j < switchJ) ? tblA[entry] : tblB[entry];
                sh    = (pass < rep) ? 0 : pass - rep + 1;
                r.audio = val >>> sh;
            end
            if (k == cutAt) begin
                r.audio = 0;
                r.busy  = 1'b0;
                r.done  = 1'b0;
            end
            expq.push_back(r);
        end
    endtask

    // Issue a start pulse sampled on the next rising edge, then queue the
    // expected trace. Returns 1 ns after that edge.
    task automatic applyStimulus(input int div, input int rep, input int stopAt,
                                 input int switchJ, input int cutAt);
        @(negedge clock);
        bus.step_div = DIV_W'(div);
        bus.repeats  = REP_W'(rep);
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        pushTrace(div, rep, stopAt, switchJ, cutAt);
    endtask

    task automatic writeTable(input int addr, input int data);
        @(negedge clock);
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = DEPTH_LOG2'(addr);
        bus.tbl_wdata = DATA_W'(data);
        tblA[addr]    = data;
        tblB[addr]    = data;
    endtask

    task automatic endWrites();
        @(negedge clock);
        bus.tbl_we = 1'b0;
    endtask

    // Wait, bounded, until the monitor has consumed every expected record.
    task automatic waitDrain();
        int budget;
        budget = 4000;
        while (expq.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        if (expq.size() > 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL drain timeout: got %0d records pending expected 0", expq.size());
            expq.delete();
        end
        repeat (3) @(posedge clock);
    endtask

    // Guard against a hung run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.step_div  = '0;
        bus.repeats   = '0;
        bus.tbl_we    = 1'b0;
        bus.tbl_waddr = '0;
        bus.tbl_wdata = '0;

        // Reset state.
        pushZero();
        pushZero();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Ramp table i*1000.
        for (int i = 0; i < DEPTH; i++) writeTable(i, i * 1000);
        endWrites();

        $display("[TB] note div=2 repeats=1");
        applyStimulus(2, 1, -1, NO_SWITCH, -1);
        waitDrain();

        $display("[TB] note div=0 repeats=0");
        applyStimulus(0, 0, -1, NO_SWITCH, -1);
        waitDrain();

        $display("[TB] stop 10 cycles into PLAY");
        applyStimulus(3, 2, 10, NO_SWITCH, -1);
        repeat (9) @(posedge clock);
        #1 bus.stop = 1'b1;
        @(posedge clock);
        #1 bus.stop = 1'b0;
        waitDrain();

        $display("[TB] restart after stop, second start ignored");
        applyStimulus(1, 1, -1, NO_SWITCH, -1);
        repeat (100) @(posedge clock);
        #1;
        bus.step_div = DIV_W'(5);
        bus.repeats  = REP_W'(2);
        bus.start    = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        waitDrain();

        $display("[TB] async reset mid-FADE");
        applyStimulus(1, 0, -1, NO_SWITCH, 100);
        repeat (100) @(posedge clock);
        #2 reset = 1'b1;
        waitDrain();
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] table intact after reset");
        applyStimulus(1, 0, -1, NO_SWITCH, -1);
        waitDrain();

        $display("[TB] write collision on table[5]");
        tblB[5] = 77;
        applyStimulus(1, 1, -1, 6, -1);
        repeat (5) @(posedge clock);
        #1;
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = DEPTH_LOG2'(5);
        bus.tbl_wdata = DATA_W'(77);
        @(posedge clock);
        #1 bus.tbl_we = 1'b0;
        waitDrain();
        tblA[5] = 77;

        $display("[TB] negative table, fade only");
        for (int i = 0; i < DEPTH; i++) writeTable(i, -7);
        endWrites();
        applyStimulus(1, 0, -1, NO_SWITCH, -1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
